// File: rtl/jedro_1_shift_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_shift_cmp_pkg
// Description : Widths and op-code encodings shared by the jedro_1 shift/compare unit.
// Revision    : 1.0 - initial release
// ============================================================================
package jedro_1_shift_cmp_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_SLTU = 3'b100;

endpackage
`default_nettype wire

// File: rtl/jedro_1_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_barrel_shifter
// Description : Log-depth right shifter (stages 1/2/4/8/16) with selectable fill bit.
// Revision    : 1.0 - initial release
// ============================================================================
module jedro_1_barrel_shifter
  import jedro_1_shift_cmp_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int SHW   = SHAMT_WIDTH
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data
);

  logic [SHW:0][WIDTH-1:0] w_stage;

  assign w_stage[0] = i_data;

  // Stage s shifts by 2**s when shift-amount bit s is set.
  for (genvar s = 0; s < SHW; s++) begin : g_stage
    localparam int c_dist = 1 << s;
    assign w_stage[s+1] = i_shamt[s] ? {{c_dist{i_fill}}, w_stage[s][WIDTH-1:c_dist]}
                                     : w_stage[s];
  end

  assign o_data = w_stage[SHW];

endmodule
`default_nettype wire

// File: rtl/jedro_1_shift_cmp_unit.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_shift_cmp_unit
// Description : Registered SLL/SRL/SRA/SLT unit; optional SLTU via JEDRO_1_SLTU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module jedro_1_shift_cmp_unit
  import jedro_1_shift_cmp_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] opa_i,
  input  logic [DATA_WIDTH-1:0] opb_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] w_opa_rev;
  logic [DATA_WIDTH-1:0] w_shift_in;
  logic [DATA_WIDTH-1:0] w_shift_out;
  logic [DATA_WIDTH-1:0] w_shift_rev;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_is_sll;
  logic                  w_fill;
  logic                  w_lt;
  logic [DATA_WIDTH-1:0] r_res;
  logic                  r_valid;

  // Left shift is a right shift of the bit-reversed operand, reversed back.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
    assign w_opa_rev[i]   = opa_i[DATA_WIDTH-1-i];
    assign w_shift_rev[i] = w_shift_out[DATA_WIDTH-1-i];
  end

  assign w_is_sll   = (op_i == OP_SLL);
  assign w_shift_in = w_is_sll ? w_opa_rev : opa_i;
  assign w_fill     = (op_i == OP_SRA) & opa_i[DATA_WIDTH-1];

  jedro_1_barrel_shifter #(
    .WIDTH (DATA_WIDTH),
    .SHW   (SHAMT_WIDTH)
  ) u_shifter (
    .i_data  (w_shift_in),
    .i_shamt (opb_i[SHAMT_WIDTH-1:0]),
    .i_fill  (w_fill),
    .o_data  (w_shift_out)
  );

  assign w_lt = $signed(opa_i) < $signed(opb_i);

`ifdef JEDRO_1_SLTU_EN
  logic w_ltu;
  assign w_ltu = opa_i < opb_i;
`endif

  always_comb begin
    w_result = '0;
    case (op_i)
      OP_SLL:  w_result = w_shift_rev;
      OP_SRL:  w_result = w_shift_out;
      OP_SRA:  w_result = w_shift_out;
      OP_SLT:  w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
`ifdef JEDRO_1_SLTU_EN
      OP_SLTU: w_result = {{(DATA_WIDTH-1){1'b0}}, w_ltu};
`endif
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_res <= w_result;
      end
    end
  end

  assign res_o   = r_res;
  assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_shift_cmp_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_jedro_1_shift_cmp_unit
// Description : Self-checking bench for jedro_1_shift_cmp_unit (JEDRO_1_SLTU_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jedro_1_shift_cmp_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] opa_i = '0;
  logic [31:0] opb_i = '0;
  logic [31:0] res_o;
  logic        valid_o;

  int errors = 0;
  int checks = 0;

  logic        m_valid = 1'b0;
  logic [31:0] m_res = '0;

  jedro_1_shift_cmp_unit dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .op_i    (op_i),
    .opa_i   (opa_i),
    .opb_i   (opb_i),
    .res_o   (res_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0: return a << sh;
      3'd1: return a >> sh;
      3'd2: return $unsigned($signed(a) >>> sh);
      3'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef JEDRO_1_SLTU_EN
      3'd4: return (a < b) ? 32'd1 : 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: what the registered outputs must hold after each edge.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid = 1'b0;
      m_res   = '0;
    end else begin
      m_valid = valid_i;
      if (valid_i) m_res = model_op(op_i, opa_i, opb_i);
    end
  end

  always @(negedge clk_i) begin
    check("valid_o_vs_model", {31'b0, valid_o}, {31'b0, m_valid});
    check("res_o_vs_model", res_o, m_res);
  end

  // Issue one request (caller is just after a rising edge), check result literal.
  task automatic req(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    valid_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check({name, "_valid"}, {31'b0, valid_o}, 32'd1);
    check(name, res_o, exp);
  endtask

  logic [2:0]  bb_op [4];
  logic [31:0] bb_a  [4];
  logic [31:0] bb_b  [4];
  logic [31:0] bb_e  [4];

  initial begin
    #2;
    check("reset_res", res_o, 32'h0);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("idle_valid", {31'b0, valid_o}, 32'd0);

    req("sll_31",    3'b000, 32'h0000_0001, 32'd31,        32'h8000_0000);
    req("sll_sh32",  3'b000, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001);
    req("srl_4",     3'b001, 32'h8000_0000, 32'd4,         32'h0800_0000);
    req("sra_4",     3'b010, 32'h8000_0000, 32'd4,         32'hF800_0000);
    req("sra_31",    3'b010, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF);
    req("srl_31",    3'b001, 32'h8000_0000, 32'd31,        32'h0000_0001);
    req("sra_pos",   3'b010, 32'h4000_0000, 32'hFFFF_FFE1, 32'h2000_0000);
    req("sll_mid",   3'b000, 32'h1234_5678, 32'd8,         32'h3456_7800);
    req("slt_minmax",3'b011, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001);
    req("slt_maxmin",3'b011, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    req("slt_eq",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    req("slt_neg1",  3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    req("sltu_big",  3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
`ifdef JEDRO_1_SLTU_EN
    req("sltu_small",3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
`else
    req("sltu_small",3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
`endif
    req("sll_hold",  3'b000, 32'h0000_00F0, 32'd4,         32'h0000_0F00);
    @(posedge clk_i); #1;
    check("hold_valid", {31'b0, valid_o}, 32'd0);
    check("hold_res", res_o, 32'h0000_0F00);
    req("undef_101", 3'b101, 32'hFFFF_FFFF, 32'd3, 32'h0);
    req("undef_110", 3'b110, 32'hFFFF_FFFF, 32'd3, 32'h0);
    req("undef_111", 3'b111, 32'hFFFF_FFFF, 32'd3, 32'h0);

    // Four requests on consecutive cycles.
    bb_op = '{3'b000, 3'b001, 3'b010, 3'b011};
    bb_a  = '{32'h0000_0003, 32'hF000_0000, 32'hF000_0000, 32'h0000_0005};
    bb_b  = '{32'd2, 32'd8, 32'd8, 32'hFFFF_FFFF};
    bb_e  = '{32'h0000_000C, 32'h00F0_0000, 32'hFFF0_0000, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; op_i = bb_op[i]; opa_i = bb_a[i]; opb_i = bb_b[i];
      @(posedge clk_i); #1;
      check("b2b_valid", {31'b0, valid_o}, 32'd1);
      check("b2b_res", res_o, bb_e[i]);
    end
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("b2b_end_valid", {31'b0, valid_o}, 32'd0);

    // Reset in the middle of a pending request.
    req("pre_rst", 3'b000, 32'h0000_0001, 32'd4, 32'h0000_0010);
    valid_i = 1'b1; op_i = 3'b000; opa_i = 32'h0000_0001; opb_i = 32'd5;
    #1 rst_i = 1'b1;
    #1;
    check("rst_mid_res", res_o, 32'h0);
    check("rst_mid_valid", {31'b0, valid_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_no_pulse", {31'b0, valid_o}, 32'd0);
    check("rst_res_zero", res_o, 32'h0);
    @(posedge clk_i); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
